// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb -- round-robin write arbiter in front of one dual-clock FIFO.
//
// Shares the FIFO write port between nr producers that all live in the
// write-clock domain. Each producer holds a word on its slice of din with
// req until ack is seen. The owner keeps the port for a bounded burst,
// and every producer is throttled on the FIFO full / almost-full flags.
//
// Optional feature macro: FIFO_ARB_BURST_EN
//   defined   : a grant lasts up to `burst` words (counter cnt_reg present)
//   undefined : every transfer releases the grant (per-word round robin)
//
// Ports:
//   clk          write-side clock (same net as FIFO wr_clk)
//   rst          synchronous active-high reset
//   req[nr]      per-requester word valid, held with data until acked
//   din[nr*dw]   flattened data, requester i at [i*dw +: dw]
//   gnt[nr]      registered one-hot owner, all-zero when idle
//   ack[nr]      combinational per-word accept
//   fifo_we      registered FIFO write strobe
//   fifo_din     registered FIFO write data
//   fifo_full    FIFO full flag
//   fifo_full_n  FIFO almost-full flag (FIFO configured with n >= 2)
module fifo_wr_arb #(
  parameter int dw    = 8,
  parameter int nr    = 4,
  parameter int burst = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [nr-1:0]      req,
  input  logic [nr*dw-1:0]   din,
  output logic [nr-1:0]      gnt,
  output logic [nr-1:0]      ack,
  output logic               fifo_we,
  output logic [dw-1:0]      fifo_din,
  input  logic               fifo_full,
  input  logic               fifo_full_n
);

  localparam int LW = (nr > 1) ? $clog2(nr) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state_reg;
  logic [nr-1:0]   gnt_reg;
  logic [LW-1:0]   last_reg;     // previous / current owner index
  logic            we_reg;
  logic [dw-1:0]   din_reg;

  logic            stall;
  logic            xfer;
  logic            any_req;
  logic            burst_done;
  logic            release_now;
  logic            win_found;
  logic [LW-1:0]   winner;
  logic [LW-1:0]   cand;
  logic [nr-1:0]   winner_onehot;
  logic [dw-1:0]   word [nr];
  logic [dw-1:0]   owner_word;

  assign stall   = fifo_full | fifo_full_n;
  assign any_req = |req;

  // Unpack the flattened data bus, build ack and the winner one-hot.
  // ack is also masked by rst so a word offered during the reset cycle is
  // never reported as accepted (it would not be written either).
  genvar gi;
  generate
    for (gi = 0; gi < nr; gi++) begin : g_lane
      assign word[gi]          = din[gi*dw +: dw];
      assign ack[gi]           = gnt_reg[gi] & req[gi] & ~stall & ~rst;
      assign winner_onehot[gi] = (winner == LW'(gi));
    end
  endgenerate

  assign xfer       = |ack;
  // Only the owner can be acked, and the owner index is last_reg.
  assign owner_word = word[last_reg];

  // Round-robin search starting one past last_reg. The previous owner is
  // the final candidate, so it only wins again when nobody else asks.
  always_comb begin
    win_found = 1'b0;
    winner    = last_reg;
    cand      = '0;
    for (int k = 1; k <= nr; k++) begin
      cand = LW'((int'(last_reg) + k) % nr);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        winner    = cand;
      end
    end
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int CW = $clog2(burst) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(burst - 1);

  logic [CW-1:0] cnt_reg;

  // Burst ends on the transfer that carries the last word of the grant.
  assign burst_done = xfer && (cnt_reg == CNT_LAST);
`else
  // Without bursts every accepted word hands the port on.
  assign burst_done = xfer;
`endif

  // Release on owner request drop or on the last word of the burst. A
  // stall blocks xfer, so it can neither release nor advance the count.
  assign release_now = (state_reg == OWN) && (!req[last_reg] || burst_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      last_reg  <= LW'(nr - 1);   // requester 0 is searched first
      we_reg    <= 1'b0;
      din_reg   <= '0;
`ifdef FIFO_ARB_BURST_EN
      cnt_reg   <= '0;
`endif
    end else begin
      we_reg <= xfer;
      if (xfer) begin
        din_reg <= owner_word;
      end

      case (state_reg)
        IDLE: begin
          if (any_req) begin
            state_reg <= OWN;
            gnt_reg   <= winner_onehot;
            last_reg  <= winner;
`ifdef FIFO_ARB_BURST_EN
            cnt_reg   <= '0;
`endif
          end
        end

        OWN: begin
          if (release_now) begin
            // Hand over in the same cycle so there is no bubble.
            if (any_req) begin
              gnt_reg  <= winner_onehot;
              last_reg <= winner;
            end else begin
              state_reg <= IDLE;
              gnt_reg   <= '0;
            end
`ifdef FIFO_ARB_BURST_EN
            cnt_reg <= '0;
`endif
          end
`ifdef FIFO_ARB_BURST_EN
          else if (xfer) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
`endif
        end

        default: begin
          state_reg <= IDLE;
          gnt_reg   <= '0;
        end
      endcase
    end
  end

  assign gnt      = gnt_reg;
  assign fifo_we  = we_reg;
  assign fifo_din = din_reg;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb (dw=8, nr=4, burst=4).
// A vector table covers reset, grant, stall, request drop and re-arbitration;
// hand-written sequences cover streaming, burst/round-robin order, FIFO
// almost-full throttling, burst counter restart and reset mid-burst.
// Expectations follow FIFO_ARB_BURST_EN when the bench is built with it.
module tb_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din_bus;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        fifo_we;
  logic [7:0]  fifo_din;
  logic        fifo_full;
  logic        fifo_full_n;
  logic [7:0]  word [4];

  int checks   = 0;
  int failures = 0;

`ifdef FIFO_ARB_BURST_EN
  localparam int BURST_RUN = 4;
`else
  localparam int BURST_RUN = 1;
`endif

  assign din_bus = {word[3], word[2], word[1], word[0]};

  always #5 clk = ~clk;

  fifo_wr_arb #(.dw(8), .nr(4), .burst(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din        (din_bus),
    .gnt        (gnt),
    .ack        (ack),
    .fifo_we    (fifo_we),
    .fifo_din   (fifo_din),
    .fifo_full  (fifo_full),
    .fifo_full_n(fifo_full_n)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       full;
    logic       af;
    logic [3:0] exp_ack;
    logic [3:0] exp_gnt;
    logic       exp_we;
    logic [7:0] exp_din;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s idx=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    fifo_full = 1'b0;
    fifo_full_n = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int   sent, nwr, last_wr, cnt_fifo, nack, run, exp_tag;
    logic granted, af, we_s, done;
    logic [3:0] ack_s, gnt_s;

    rst = 1'b1; req = '0; fifo_full = 1'b0; fifo_full_n = 1'b0;
    word[0] = 8'h11; word[1] = 8'h22; word[2] = 8'h33; word[3] = 8'h44;

    //            rst req     full af   ack     gnt     we   din
    vecs[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'h22};
    vecs[3]  = '{1'b0, 4'b0010, 1'b0, 1'b1, 4'b0000, 4'b0010, 1'b0, 8'h22};
    vecs[4]  = '{1'b0, 4'b0010, 1'b1, 1'b0, 4'b0000, 4'b0010, 1'b0, 8'h22};
    vecs[5]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'h22};
    vecs[6]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0100, 1'b0, 8'h22};
    vecs[7]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'h33};
    vecs[8]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h33};
    vecs[9]  = '{1'b0, 4'b1001, 1'b0, 1'b0, 4'b0000, 4'b1000, 1'b0, 8'h33};
    vecs[10] = '{1'b0, 4'b1001, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0, 8'h33};
    vecs[11] = '{1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0, 8'h33};
    vecs[12] = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h11};
    vecs[13] = '{1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
    vecs[14] = '{1'b0, 4'b0110, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0, 8'h00};

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 15; i++) begin
      rst = vecs[i].rst; req = vecs[i].req;
      fifo_full = vecs[i].full; fifo_full_n = vecs[i].af;
      #1;
      chk("T_ack", i, ack, vecs[i].exp_ack);
      tick();
      chk("T_gnt", i, gnt, vecs[i].exp_gnt);
      chk("T_we", i, fifo_we, vecs[i].exp_we);
      chk("T_din", i, fifo_din, vecs[i].exp_din);
      $display("vec %0d rst=%b req=%b gnt=%b we=%b din=%h", i, vecs[i].rst,
               vecs[i].req, gnt, fifo_we, fifo_din);
    end

    // ---------------- A: single requester, 6 words ----------------
    do_reset();
    word[0] = 8'h10; req = 4'b0001; sent = 0; nwr = 0; granted = 1'b0; last_wr = -10;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (fifo_we) begin
        chk("A_data", nwr, fifo_din, 8'h10 + nwr);
        if (nwr > 0) chk("A_gap", nwr, c - last_wr, 1);
        $display("A write %0d data=%h", nwr, fifo_din);
        last_wr = c; nwr++;
      end
      if (gnt != 4'b0000) granted = 1'b1;
      if (granted && sent < 6) chk("A_gnt", c, gnt, 4'b0001);
      ack_s = ack;
      tick();
      if (ack_s[0]) begin
        sent++;
        word[0] = word[0] + 8'h01;
        if (sent == 6) req = 4'b0000;
      end
    end
    chk("A_nwrites", 0, nwr, 6);

    // ---------------- B: all four requesters streaming tags ----------------
    do_reset();
    for (int i = 0; i < 4; i++) word[i] = 8'hA0 + 8'(i);
    req = 4'b1111; nwr = 0; last_wr = -10;
    for (int c = 0; c < 24; c++) begin
      #1;
      chk("B_ack_onehot", c, $onehot0(ack), 1);
      if (fifo_we && nwr < 16) begin
        exp_tag = (nwr / BURST_RUN) % 4;
        chk("B_tag", nwr, fifo_din, 8'hA0 + exp_tag);
        if (nwr > 0) chk("B_gap", nwr, c - last_wr, 1);
        $display("B write %0d data=%h", nwr, fifo_din);
        last_wr = c; nwr++;
      end
      tick();
    end
    chk("B_nwrites", 0, nwr, 16);

    // ---------------- C: throttle on almost-full, depth 8, n=2 ----------------
    do_reset();
    word[0] = 8'h00; req = 4'b0001; cnt_fifo = 0; af = 1'b0;
    for (int c = 0; c < 24; c++) begin
      fifo_full = (cnt_fifo == 8); fifo_full_n = af;
      #1;
      chk("C_we_full", c, fifo_we & fifo_full, 0);
      chk("C_ack_stall", c, (|ack) & (fifo_full | fifo_full_n), 0);
      if (fifo_we) begin
        chk("C_data", c, fifo_din, cnt_fifo);
        $display("C write %0d data=%h", cnt_fifo, fifo_din);
      end
      we_s = fifo_we; ack_s = ack;
      tick();
      af = (cnt_fifo >= 6);   // almost-full seen one stage late
      if (we_s) cnt_fifo++;
      if (ack_s[0]) word[0] = word[0] + 8'h01;
    end
    chk("C_stored", 0, cnt_fifo, 8);

    // ---------------- D: owner drops mid-burst, counter restarts ----------------
    do_reset();
    word[1] = 8'h51; word[2] = 8'h62; req = 4'b0010; nack = 0;
    for (int c = 0; c < 10 && nack < 2; c++) begin
      #1;
      if (ack[1]) nack++;
      tick();
    end
    chk("D_r1_acks", 0, nack, 2);
    req = 4'b0100;
    #1;
    chk("D_drop_ack", 0, ack, 4'b0000);
    tick();
    chk("D_gnt_r2", 0, gnt, 4'b0100);
    req = 4'b0110; run = 0; done = 1'b0; gnt_s = '0;
    for (int c = 0; c < 12 && !done; c++) begin
      #1;
      if (ack[2]) run++;
      else if (run > 0) begin done = 1'b1; gnt_s = gnt; end
      tick();
    end
    chk("D_run", 0, run, BURST_RUN);
    chk("D_next_owner", 0, gnt_s, 4'b0010);
    $display("D r2 run=%0d next_gnt=%b", run, gnt_s);

    // ---------------- E: reset pulse mid-burst ----------------
    do_reset();
    for (int i = 0; i < 4; i++) word[i] = 8'hA0 + 8'(i);
    req = 4'b1111;
    tick(); tick(); tick();
    chk("E_we_before", 0, fifo_we, 1);
    rst = 1'b1;
    #1;
    chk("E_ack_in_rst", 0, ack, 4'b0000);
    tick();
    chk("E_gnt", 0, gnt, 4'b0000);
    chk("E_we", 0, fifo_we, 0);
    chk("E_din", 0, fifo_din, 8'h00);
    rst = 1'b0; req = 4'b1100;
    #1;
    chk("E_ack_idle", 0, ack, 4'b0000);
    tick();
    chk("E_first_gnt", 0, gnt, 4'b0100);
    $display("E after reset gnt=%b", gnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
